spm_driver: RTL
===============

Name: spm_driver

Overview:
Sequencing front/back end for the serial-parallel multiplier. Accepts a pair of SIZE-bit signed operands over a valid/ready handshake and clears the external multiplier. It presents the multiplicand in parallel and streams the multiplier LSB-first, sign-extended, for 2*SIZE bits. It then deserialises the multiplier's serial product output into a 2*SIZE-bit signed result, returned over a second valid/ready handshake.

Parameters:
SIZE, 32, operand width in bits; must match the attached multiplier's SIZE; result is 2*SIZE bits.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand pair offered
in_ready  output  1  driver can accept an operand pair
in_x  input  SIZE  multiplicand, signed two's complement
in_y  input  SIZE  multiplier, signed two's complement
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
out_prod  output  2*SIZE  signed product
busy  output  1  high in any state other than IDLE
spm_rst  output  1  reset to the multiplier
spm_x  output  SIZE  parallel operand to the multiplier
spm_y  output  1  serial operand to the multiplier
spm_p  input  1  serial product from the multiplier, registered there, one cycle behind spm_y

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, x_q=0, y_sr=0, prod_sr=0, out_valid=0, out_prod=0. spm_rst=1 combinationally (spm_rst = rst | clr_q).
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch x_q=in_x and y_sr=in_y sign-extended to 2*SIZE bits, then go to CLR.
  - CLR: exactly 1 cycle. clr_q=1 (registered), so spm_rst=1. spm_y=0. Go to SHIFT with cnt=0.
  - SHIFT: cycles cnt=0..2*SIZE (2*SIZE+1 cycles).
    - spm_y = y_sr[0]. y_sr shifts right each cycle, replicating its MSB.
    - When cnt>=1, spm_p is product bit cnt-1: shift it into prod_sr from the MSB end (right shift).
    - At cnt=2*SIZE, go to DONE.
  - DONE: out_valid=1 and out_prod=prod_sr, both stable until out_ready=1. On out_valid&out_ready, go to IDLE.
- spm_x = x_q in CLR and SHIFT; 0 in IDLE and DONE. spm_y=0 outside SHIFT.
- in_ready=1 only in IDLE. There is no overlap of operations, and in_valid is ignored elsewhere.
- Latency: out_valid rises 2*SIZE+2 cycles after the input handshake edge (1 CLR + 2*SIZE+1 SHIFT).
- Arithmetic: out_prod = signed(in_x) * signed(in_y), exact in 2*SIZE bits. No overflow is possible.
- In DONE, an in_valid that arrives together with out_ready is not accepted in that cycle. It is accepted one cycle later in IDLE.
- out_ready held high with no pending result has no effect.
- Reset mid-operation: abort immediately, return to IDLE, produce no out_valid, discard partial product. The multiplier is cleared via spm_rst.
- cnt width: clog2(2*SIZE+1). cnt holds 0 outside SHIFT.

Optional Feature:
Macro SPM_DRIVER_MAC_EN.
- Defined:
  - Adds input port in_acc_clr (1 bit), sampled at the input handshake.
  - Adds a 2*SIZE accumulator acc (reset 0).
  - On entering DONE: acc <= (in_acc_clr_q ? 0 : acc) + product, wrapping mod 2^(2*SIZE).
  - out_prod presents the new acc value.
- Undefined:
  - No port and no acc register.
  - out_prod is the raw product.

Test Plan:
- SIZE=32, in_x=3, in_y=5, out_ready=1 -> out_prod=0x000000000000000F, out_valid exactly 66 cycles after handshake, spm_rst high for one cycle after accept.
- in_x=-7 (0xFFFFFFF9), in_y=6 -> out_prod=0xFFFFFFFFFFFFFFD6; in_x=in_y=0xFFFFFFFF -> 0x0000000000000001.
- in_x=in_y=0x7FFFFFFF -> 0x3FFFFFFF00000001; in_x=in_y=0x80000000 -> 0x4000000000000000.
- Result pending with out_ready=0 for 10 cycles while in_valid=1 -> out_prod stable, in_ready=0, no second accept. out_ready pulses -> IDLE, next pair accepted the following cycle.
- rst pulsed at SHIFT cnt=20 -> busy=0, out_valid=0, spm_rst=1 during rst. Next operation 2*3 -> 6 correct.
- SPM_DRIVER_MAC_EN: (2,3, clr=1), (4,5, clr=0), (-10,2, clr=0) -> out_prod 6, 26, 6. Then (1,1, clr=1) -> 1.

Source files
------------

// File: rtl/spm_driver.sv
// spm_driver: sequencing front/back end for an external serial-parallel multiplier.
// Accepts a signed operand pair, clears the multiplier, presents the multiplicand in
// parallel, streams the sign-extended multiplier LSB-first for 2*SIZE bits and
// deserialises the serial product into a 2*SIZE-bit signed result.
// Optional multiply-accumulate mode is enabled by defining SPM_DRIVER_MAC_EN.
module spm_driver #(
  parameter int unsigned SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
`ifdef SPM_DRIVER_MAC_EN
  input  logic              in_acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_prod,
  output logic              busy,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
);

  localparam int unsigned PW = 2 * SIZE;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam logic [CW-1:0] CntLast = CW'(PW);

  typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] x_q, x_d;
  logic [PW-1:0]   y_sr_q, y_sr_d;
  logic [PW-1:0]   prod_sr_q, prod_sr_d;
  logic            clr_q, clr_d;

`ifdef SPM_DRIVER_MAC_EN
  logic            acc_clr_q, acc_clr_d;
  logic [PW-1:0]   acc_q, acc_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= '0;
      y_sr_q    <= '0;
      prod_sr_q <= '0;
      clr_q     <= 1'b0;
`ifdef SPM_DRIVER_MAC_EN
      acc_clr_q <= 1'b0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_sr_q    <= y_sr_d;
      prod_sr_q <= prod_sr_d;
      clr_q     <= clr_d;
`ifdef SPM_DRIVER_MAC_EN
      acc_clr_q <= acc_clr_d;
      acc_q     <= acc_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_sr_d    = y_sr_q;
    prod_sr_d = prod_sr_q;
`ifdef SPM_DRIVER_MAC_EN
    acc_clr_d = acc_clr_q;
    acc_d     = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          y_sr_d  = {{SIZE{in_y[SIZE-1]}}, in_y};
          state_d = StClr;
`ifdef SPM_DRIVER_MAC_EN
          acc_clr_d = in_acc_clr;
`endif
        end
      end
      StClr: begin
        cnt_d     = '0;
        prod_sr_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        y_sr_d = {y_sr_q[PW-1], y_sr_q[PW-1:1]};
        // Product bit cnt-1 arrives one cycle behind the serial operand bit
        if (cnt_q != '0) begin
          prod_sr_d = {spm_p, prod_sr_q[PW-1:1]};
        end
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
`ifdef SPM_DRIVER_MAC_EN
          acc_d = (acc_clr_q ? '0 : acc_q) + prod_sr_d;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    clr_d = (state_d == StClr);
  end

  // Handshake and multiplier-facing outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    spm_rst   = rst | clr_q;
    spm_x     = ((state_q == StClr) || (state_q == StShift)) ? x_q : '0;
    spm_y     = (state_q == StShift) ? y_sr_q[0] : 1'b0;
`ifdef SPM_DRIVER_MAC_EN
    out_prod  = (state_q == StDone) ? acc_q : '0;
`else
    out_prod  = (state_q == StDone) ? prod_sr_q : '0;
`endif
  end

endmodule
